// File: rtl/eth_crc_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : eth_crc_pkg
//  Purpose    : Ethernet CRC-32 constants, the per-byte CRC step shared by
//               the TX generator and the RX FCS checker, and the checker's
//               FSM state type.
//  Contents   : CRC32_POLY, CRC32_INIT, CRC32_RESIDUE, crc32_byte(),
//               fcs_chk_state_t
//  Revision   : 1.0  initial release
// ============================================================================
package eth_crc_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } fcs_chk_state_t;

  // One byte through the CRC register. Bits enter LSB first (wire order),
  // the register itself shifts MSB first with no reflection or inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_fcs_checker_if.sv
`default_nettype none
// ============================================================================
//  Interface  : eth_fcs_checker_if
//  Purpose    : RX byte stream into the FCS checker, payload stream and
//               frame status out of it.
//  Modports   : master - byte source / result sink (deserialiser side)
//               slave  - the FCS checker
//  Signals    : rx_valid, rx_data[7:0], rx_sof, rx_eof, rx_abort,
//               out_valid, out_data[7:0], out_sof, out_eof, frame_done,
//               fcs_ok, runt_err, oversize_err, abort_err, frame_len[15:0]
//  Revision   : 1.0  initial release
// ============================================================================
interface eth_fcs_checker_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_abort;

  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        frame_done;
  logic        fcs_ok;
  logic        runt_err;
  logic        oversize_err;
  logic        abort_err;
  logic [15:0] frame_len;

  modport master (
    output rx_valid, rx_data, rx_sof, rx_eof, rx_abort,
    input  out_valid, out_data, out_sof, out_eof, frame_done,
    input  fcs_ok, runt_err, oversize_err, abort_err, frame_len
  );

  modport slave (
    input  rx_valid, rx_data, rx_sof, rx_eof, rx_abort,
    output out_valid, out_data, out_sof, out_eof, frame_done,
    output fcs_ok, runt_err, oversize_err, abort_err, frame_len
  );

endinterface
`default_nettype wire

// File: rtl/eth_fcs_checker_delay_line.sv
`default_nettype none
// ============================================================================
//  Module     : fcs_delay_line
//  Purpose    : 4-byte delay line that holds back the trailing FCS bytes.
//               Once full, each push pops the oldest byte.
//  Ports      : clk, n_rst      clock / async active-low reset
//               push, din[7:0]  byte entering the line
//               flush           discard the line contents
//               pop_valid       oldest byte leaves this cycle (comb.)
//               dout[7:0]       oldest byte
//               first           this pop is the first since the last flush
//  Revision   : 1.0  initial release
// ============================================================================
module fcs_delay_line (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       flush,
  output logic       pop_valid,
  output logic [7:0] dout,
  output logic       first
);

  logic [3:0][7:0] r_mem;
  logic [2:0]      r_count;
  logic            r_popped;
  logic            w_full;

  assign w_full    = (r_count == 3'd4);
  assign pop_valid = push & w_full;
  assign dout      = r_mem[0];
  assign first     = ~r_popped;

  // Flush together with push restarts the line holding only din. At end of
  // frame this parks the last FCS byte; it can never be popped because the
  // next frame's start also flushes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mem    <= '0;
      r_count  <= 3'd0;
      r_popped <= 1'b0;
    end else if (flush) begin
      r_popped <= 1'b0;
      if (push) begin
        r_mem[0] <= din;
        r_count  <= 3'd1;
      end else begin
        r_count  <= 3'd0;
      end
    end else if (push) begin
      if (w_full) begin
        r_mem    <= {din, r_mem[3:1]};
        r_popped <= 1'b1;
      end else begin
        r_mem[r_count[1:0]] <= din;
        r_count             <= r_count + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_fcs_checker.sv
`default_nettype none
// ============================================================================
//  Module     : eth_fcs_checker
//  Purpose    : RX Ethernet FCS checker. Runs CRC-32 over every frame byte,
//               forwards the payload with the 4 FCS bytes stripped and
//               reports per-frame status with a frame_done pulse.
//  Ports      : clk    clock, rising edge
//               n_rst  asynchronous active-low reset
//               bus    eth_fcs_checker_if.slave (rx stream in, payload and
//                      status out)
//  Revision   : 1.0  initial release
// ============================================================================
module eth_fcs_checker
  import eth_crc_pkg::*;
#(
  parameter int unsigned MIN_FRAME   = 64,
  parameter int unsigned MAX_FRAME   = 1518,
  parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE
) (
  input  logic                 clk,
  input  logic                 n_rst,
  eth_fcs_checker_if.slave     bus
);

  fcs_chk_state_t r_state;
  logic [31:0]    r_crc;
  logic [15:0]    r_len;

  logic        w_in_recv;
  logic        w_take;
  logic        w_sof;
  logic        w_restart;
  logic        w_eof;
  logic        w_abort;
  logic        w_close_abort;
  logic [31:0] w_crc_next;
  logic [15:0] w_len_next;
  logic        w_runt;
  logic        w_over;
  logic        w_flush;
  logic        w_emit;
  logic        w_pop_valid;
  logic [7:0]  w_pop_data;
  logic        w_pop_first;

  assign w_in_recv = (r_state == RECV);
  // rx_abort blocks the byte of its cycle, so an abort+sof pair drops the sof.
  assign w_take    = bus.rx_valid & ~bus.rx_abort & (w_in_recv | bus.rx_sof);
  assign w_sof     = w_take & bus.rx_sof;
  assign w_restart = w_sof & w_in_recv;
  // A sof that restarts a frame never also closes the new frame.
  assign w_eof     = w_take & bus.rx_eof & ~w_restart;
  assign w_abort   = w_in_recv & bus.rx_abort;
  assign w_close_abort = w_abort | w_restart;

  assign w_crc_next = crc32_byte(w_sof ? CRC32_INIT : r_crc, bus.rx_data);
  assign w_len_next = w_sof ? 16'd1 :
                      (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
  assign w_runt     = (32'(w_len_next) < MIN_FRAME);
  assign w_over     = (32'(w_len_next) > MAX_FRAME);

  assign w_flush = w_sof | w_abort | w_eof;
  // A pop on a restart byte belongs to the abandoned frame and is dropped.
  assign w_emit  = w_pop_valid & ~w_sof;

  fcs_delay_line u_delay_line (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (w_take),
    .din       (bus.rx_data),
    .flush     (w_flush),
    .pop_valid (w_pop_valid),
    .dout      (w_pop_data),
    .first     (w_pop_first)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state          <= IDLE;
      r_crc            <= CRC32_INIT;
      r_len            <= 16'd0;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= 8'd0;
      bus.out_sof      <= 1'b0;
      bus.out_eof      <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.fcs_ok       <= 1'b0;
      bus.runt_err     <= 1'b0;
      bus.oversize_err <= 1'b0;
      bus.abort_err    <= 1'b0;
      bus.frame_len    <= 16'd0;
    end else begin
      if (w_eof || w_abort) r_state <= IDLE;
      else if (w_sof)       r_state <= RECV;

      if (w_take) begin
        r_crc <= w_crc_next;
        r_len <= w_len_next;
      end

      bus.out_valid <= w_emit;
      bus.out_data  <= w_emit ? w_pop_data : 8'd0;
      bus.out_sof   <= w_emit & w_pop_first;
      bus.out_eof   <= w_emit & w_eof;

      bus.frame_done   <= w_eof | w_close_abort;
      bus.fcs_ok       <= w_eof & (w_crc_next == CRC_RESIDUE) & ~w_runt & ~w_over;
      bus.runt_err     <= w_eof & w_runt;
      bus.oversize_err <= w_eof & w_over;
      bus.abort_err    <= w_close_abort;

      // An aborted frame reports the bytes taken before the abort cycle.
      if (w_eof)              bus.frame_len <= w_len_next;
      else if (w_close_abort) bus.frame_len <= r_len;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_fcs_checker.sv
`default_nettype none
// ============================================================================
//  Module     : tb_eth_fcs_checker
//  Purpose    : Self-checking bench for eth_fcs_checker. Directed frames are
//               driven in sequence; expected payload bytes and frame status
//               are queued as each frame is driven and compared as the DUT
//               produces them.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_eth_fcs_checker;

  localparam int MIN_F = 5;
  localparam int MAX_F = 40;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } out_t;

  typedef struct {
    logic        ok;
    logic        runt;
    logic        over;
    logic        abrt;
    logic [15:0] len;
  } st_t;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  eth_fcs_checker_if bus();

  eth_fcs_checker #(
    .MIN_FRAME   (MIN_F),
    .MAX_FRAME   (MAX_F),
    .CRC_RESIDUE (32'hC704DD7B)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  out_t        exp_out[$];
  st_t         exp_st[$];
  logic [7:0]  frame_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] last_len = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference CRC-32 in the usual reflected form; result is the FCS value.
  function automatic logic [31:0] fcs_model(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frame_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_good(input int n, input int seed);
    logic [31:0] f;
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'(seed + i * 13));
    f = fcs_model(n);
    frame_q.push_back(f[7:0]);
    frame_q.push_back(f[15:8]);
    frame_q.push_back(f[23:16]);
    frame_q.push_back(f[31:24]);
  endtask

  task automatic exp_frame(input int len, input logic crc_good);
    st_t s;
    for (int i = 0; i <= len - 5; i++)
      exp_out.push_back('{d: frame_q[i], sof: (i == 0), eof: (i == len - 5)});
    s.ok   = crc_good && (len >= MIN_F) && (len <= MAX_F);
    s.runt = (len < MIN_F);
    s.over = (len > MAX_F);
    s.abrt = 1'b0;
    s.len  = 16'(len);
    exp_st.push_back(s);
  endtask

  task automatic exp_abort(input int taken);
    for (int i = 0; i <= taken - 5; i++)
      exp_out.push_back('{d: frame_q[i], sof: (i == 0), eof: 1'b0});
    exp_st.push_back('{ok: 1'b0, runt: 1'b0, over: 1'b0, abrt: 1'b1, len: 16'(taken)});
  endtask

  task automatic drive(input logic [7:0] d, input logic s, input logic e,
                       input logic v = 1'b1, input logic a = 1'b0);
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.rx_sof   = s;
    bus.rx_eof   = e;
    bus.rx_abort = a;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.rx_sof   = 1'b0;
    bus.rx_eof   = 1'b0;
    bus.rx_abort = 1'b0;
  endtask

  task automatic send_bytes(input int first, input int count, input int gap, input bit with_eof);
    for (int i = first; i < first + count; i++) begin
      drive(frame_q[i], (i == 0), with_eof && (i == frame_q.size() - 1));
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_out.size() != 0 || exp_st.size() != 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("queues_drained", 32'(exp_out.size() + exp_st.size()), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  // Output monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    out_t eo;
    st_t  es;
    if (!n_rst) begin
      last_len = 16'd0;
    end else begin
      if (bus.out_valid) begin
        chk("out_valid_expected", 32'(exp_out.size() != 0), 32'd1);
        if (exp_out.size() != 0) begin
          eo = exp_out.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(eo.d));
          chk("out_sof", 32'(bus.out_sof), 32'(eo.sof));
          chk("out_eof", 32'(bus.out_eof), 32'(eo.eof));
        end
      end else begin
        chk("out_flags_idle", 32'({bus.out_sof, bus.out_eof}), 32'd0);
      end
      if (bus.frame_done) begin
        chk("frame_done_expected", 32'(exp_st.size() != 0), 32'd1);
        if (exp_st.size() != 0) begin
          es = exp_st.pop_front();
          chk("fcs_ok", 32'(bus.fcs_ok), 32'(es.ok));
          chk("runt_err", 32'(bus.runt_err), 32'(es.runt));
          chk("oversize_err", 32'(bus.oversize_err), 32'(es.over));
          chk("abort_err", 32'(bus.abort_err), 32'(es.abrt));
          chk("frame_len", 32'(bus.frame_len), 32'(es.len));
          last_len = es.len;
        end
      end else begin
        chk("status_idle", 32'({bus.fcs_ok, bus.runt_err, bus.oversize_err, bus.abort_err}), 32'd0);
        chk("frame_len_hold", 32'(bus.frame_len), 32'(last_len));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.rx_sof   = 1'b0;
    bus.rx_eof   = 1'b0;
    bus.rx_abort = 1'b0;
    n_rst        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_status", 32'({bus.fcs_ok, bus.runt_err, bus.oversize_err, bus.abort_err}), 32'd0);
    chk("rst_frame_len", 32'(bus.frame_len), 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Reference frame "123456789" with its FCS.
    frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
    exp_frame(13, 1'b1);
    send_bytes(0, 13, 0, 1'b1);
    wait_drain();

    // Same frame with one payload byte corrupted.
    frame_q[4] = 8'h34;
    exp_frame(13, 1'b0);
    send_bytes(0, 13, 0, 1'b1);
    wait_drain();

    // Runts: 3, 1 and 4 bytes; then the shortest legal frame (5 bytes).
    frame_q = '{8'hA1, 8'hA2, 8'hA3};
    exp_frame(3, 1'b0);
    send_bytes(0, 3, 0, 1'b1);
    frame_q = '{8'h55};
    exp_frame(1, 1'b0);
    send_bytes(0, 1, 0, 1'b1);
    frame_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    exp_frame(4, 1'b0);
    send_bytes(0, 4, 0, 1'b1);
    build_good(1, 8'h5A);
    exp_frame(5, 1'b1);
    send_bytes(0, 5, 0, 1'b1);
    wait_drain();

    // Abort after byte 7 of a 20-byte frame, then a good frame.
    build_good(16, 3);
    exp_abort(7);
    send_bytes(0, 7, 0, 1'b0);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    build_good(10, 77);
    exp_frame(14, 1'b1);
    send_bytes(0, 14, 0, 1'b1);
    wait_drain();

    // New sof after byte 10 with no eof, then a complete good frame.
    build_good(16, 9);
    exp_abort(10);
    send_bytes(0, 10, 0, 1'b0);
    build_good(16, 200);
    exp_frame(20, 1'b1);
    send_bytes(0, 20, 0, 1'b1);
    wait_drain();

    // Length boundaries at MAX_FRAME: 40 is legal, 41 is oversize.
    build_good(36, 17);
    exp_frame(40, 1'b1);
    send_bytes(0, 40, 0, 1'b1);
    build_good(37, 18);
    exp_frame(41, 1'b1);
    send_bytes(0, 41, 0, 1'b1);
    wait_drain();

    // Reset mid-frame: no frame_done, everything back to reset values.
    build_good(12, 44);
    send_bytes(0, 3, 0, 1'b0);
    n_rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_frame_len", 32'(bus.frame_len), 32'd0);
    chk("midrst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    n_rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    // The same frame again, with idle gaps between bytes.
    exp_frame(16, 1'b1);
    send_bytes(0, 16, 2, 1'b1);
    wait_drain();

    // Abort and sof together mid-frame: abort wins, sof byte dropped, and
    // the following bytes without sof are ignored, as is an idle abort.
    build_good(8, 123);
    exp_abort(6);
    send_bytes(0, 6, 0, 1'b0);
    drive(frame_q[0], 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < 12; i++) drive(frame_q[i], 1'b0, (i == 11));
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
